// File: rtl/nn_fp_pkg.sv
// nn_fp_pkg: shared fp32 type, constants, default core latencies and update FSM states
package nn_fp_pkg;
    typedef logic [31:0] fp32_t;
    localparam fp32_t FP_ZERO = 32'h0000_0000;
    localparam fp32_t FP_ONE = 32'h3F80_0000;
    localparam int DEF_ADD_LAT = 7;
    localparam int DEF_MUL_LAT = 5;
    typedef enum logic [2:0] {IDLE, ERR, SCALE, ISSUE, DRAIN, DONE} wu_state_e;
endpackage

// File: rtl/weight_update_engine_if.sv
// weight_update_engine_if: controller-side request/operand/status bundle of the weight update engine
//   master: drives iSTART, iLOAD, iLOAD_DATA, iTEACH, iOUTPUT, iLEARN_RATE, iMID_VALUE
//   slave : drives oBUSY, oDONE, oWEIGHT
interface weight_update_engine_if #(parameter int N_MID = 4);
    import nn_fp_pkg::*;
    logic iSTART;
    logic iLOAD;
    logic [N_MID*32-1:0] iLOAD_DATA;
    fp32_t iTEACH;
    fp32_t iOUTPUT;
    fp32_t iLEARN_RATE;
    logic [N_MID*32-1:0] iMID_VALUE;
    logic oBUSY;
    logic oDONE;
    logic [N_MID*32-1:0] oWEIGHT;
    modport master (output iSTART, iLOAD, iLOAD_DATA, iTEACH, iOUTPUT, iLEARN_RATE, iMID_VALUE,
                    input oBUSY, oDONE, oWEIGHT);
    modport slave (input iSTART, iLOAD, iLOAD_DATA, iTEACH, iOUTPUT, iLEARN_RATE, iMID_VALUE,
                   output oBUSY, oDONE, oWEIGHT);
endinterface

// File: rtl/fp_add_sub.sv
// fp_add_sub: fixed-latency fp32 adder/subtractor (truncating, zero/denormal inputs treated as zero)
//   iCLK        : clock (pipeline is not reset)
//   iSUB        : 1 computes iA - iB, 0 computes iA + iB
//   iA, iB      : operands
//   oRESULT     : result, LAT cycles after the operands
module fp_add_sub
    import nn_fp_pkg::*;
#(
    parameter int LAT = DEF_ADD_LAT
) (
    input logic iCLK,
    input logic iSUB,
    input fp32_t iA,
    input fp32_t iB,
    output fp32_t oRESULT
);
    fp32_t b, hi, lo, res;
    fp32_t pipe [LAT];
    logic [7:0] d;
    logic [27:0] mx, my, ms, norm;
    int p;
    always_comb begin
        b = {iB[31] ^ iSUB, iB[30:0]};
        hi = (b[30:0] > iA[30:0]) ? b : iA;
        lo = (b[30:0] > iA[30:0]) ? iA : b;
        d = hi[30:23] - lo[30:23];
        mx = {2'b01, hi[22:0], 3'b000};
        my = (d > 8'd26) ? '0 : ({2'b01, lo[22:0], 3'b000} >> d);
        ms = (hi[31] == lo[31]) ? mx + my : mx - my;
        p = 0;
        for (int i = 0; i < 27; i++) if (ms[i]) p = i;
        norm = ms << (26 - p);
        res = ms[27] ? {hi[31], hi[30:23] + 8'd1, 23'(ms >> 4)}
                     : {hi[31], hi[30:23] - 8'(26 - p), 23'(norm >> 3)};
        res = (lo[30:23] == 8'd0) ? hi : (ms == '0) ? FP_ZERO : res;
    end
    always_ff @(posedge iCLK) begin
        pipe[0] <= res;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign oRESULT = pipe[LAT-1];
endmodule

// File: rtl/fp_mult.sv
// fp_mult: fixed-latency fp32 multiplier (truncating, zero/denormal inputs give +0)
//   iCLK        : clock (pipeline is not reset)
//   iA, iB      : operands
//   oRESULT     : product, LAT cycles after the operands
module fp_mult
    import nn_fp_pkg::*;
#(
    parameter int LAT = DEF_MUL_LAT
) (
    input logic iCLK,
    input fp32_t iA,
    input fp32_t iB,
    output fp32_t oRESULT
);
    logic [47:0] pm;
    logic [7:0] e;
    fp32_t res;
    fp32_t pipe [LAT];
    always_comb begin
        pm = {24'd0, 1'b1, iA[22:0]} * {24'd0, 1'b1, iB[22:0]};
        e = iA[30:23] + iB[30:23] - 8'd127 + {7'd0, pm[47]};
        res = (iA[30:23] == 8'd0 || iB[30:23] == 8'd0) ? FP_ZERO
            : {iA[31] ^ iB[31], e, pm[47] ? 23'(pm >> 24) : 23'(pm >> 23)};
    end
    always_ff @(posedge iCLK) begin
        pipe[0] <= res;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign oRESULT = pipe[LAT-1];
endmodule

// File: rtl/wu_tag_pipe.sv
// wu_tag_pipe: {valid, index} shift register tracking an FP core's issue-to-result alignment
//   iCLK, iRST_N    : clock, asynchronous active-low reset
//   iVALID, iIDX    : tag entering with the issued operation
//   oVALID, oIDX    : same tag, LAT cycles later, alongside the core result
module wu_tag_pipe #(
    parameter int LAT = 1,
    parameter int IW = 1
) (
    input logic iCLK,
    input logic iRST_N,
    input logic iVALID,
    input logic [IW-1:0] iIDX,
    output logic oVALID,
    output logic [IW-1:0] oIDX
);
    logic [LAT-1:0] vld;
    logic [IW-1:0] idx [LAT];
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) idx[i] <= '0;
        end else begin
            vld[0] <= iVALID;
            idx[0] <= iIDX;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end
    assign oVALID = vld[LAT-1];
    assign oIDX = idx[LAT-1];
endmodule

// File: rtl/weight_update_engine.sv
// weight_update_engine: delta-rule update w[k] += eta*(teach-output)*mid[k] on one shared adder and multiplier
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   bus (slave)  : iSTART/iLOAD requests and operands in; oBUSY, oDONE, registered oWEIGHT out
module weight_update_engine
    import nn_fp_pkg::*;
#(
    parameter int N_MID = 4,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DW = 32
) (
    input logic iCLK,
    input logic iRST_N,
    weight_update_engine_if.slave bus
);
    localparam int IW = N_MID > 1 ? $clog2(N_MID) : 1;
    localparam int LMAX = ADD_LAT > MUL_LAT ? ADD_LAT : MUL_LAT;
    localparam int CW = $clog2((LMAX > N_MID ? LMAX : N_MID) + 1);
    wu_state_e state, nextState;
    logic [CW-1:0] cnt;
    fp32_t [N_MID-1:0] weight, mid;
    fp32_t teach, outVal, eta, midSel, wSel, addA, addB, addR, mulA, mulB, mulR;
    logic [DW-1:0] scale;
    logic issue, addSub, mulV, addV;
    logic [IW-1:0] mulIdx, addIdx;
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= nextState;
            cnt <= (nextState != state) ? '0 : cnt + CW'(1);
        end
    end
    // Channels retire in issue order, so the last index leaving the adder means both pipes are empty.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = (bus.iSTART && !bus.iLOAD) ? ERR : IDLE;
            ERR:     nextState = (cnt == CW'(ADD_LAT - 1)) ? SCALE : ERR;
            SCALE:   nextState = (cnt == CW'(MUL_LAT - 1)) ? ISSUE : SCALE;
            ISSUE:   nextState = (cnt == CW'(N_MID - 1)) ? DRAIN : ISSUE;
            DRAIN:   nextState = (addV && addIdx == IW'(N_MID - 1)) ? DONE : DRAIN;
            default: nextState = IDLE;
        endcase
    end
    // The scale factor leaves the multiplier only in the first ISSUE cycle; it is used directly then and held in scale after.
    always_comb begin
        issue = state == ISSUE;
        addSub = state == ERR;
        midSel = mid[0];
        wSel = weight[0];
        for (int k = 0; k < N_MID; k++) begin
            if (cnt == CW'(k)) midSel = mid[k];
            if (mulIdx == IW'(k)) wSel = weight[k];
        end
        addA = addSub ? teach : wSel;
        addB = addSub ? outVal : mulR;
        mulA = (state == SCALE) ? addR : (issue && cnt == '0) ? mulR : scale;
        mulB = (state == SCALE) ? eta : midSel;
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            weight <= '0;
            mid <= '0;
            teach <= FP_ZERO;
            outVal <= FP_ZERO;
            eta <= FP_ZERO;
            scale <= '0;
        end else begin
            if (state == IDLE && bus.iLOAD) weight <= bus.iLOAD_DATA;
            if (state == IDLE && bus.iSTART && !bus.iLOAD) begin
                teach <= bus.iTEACH;
                outVal <= bus.iOUTPUT;
                eta <= bus.iLEARN_RATE;
                mid <= bus.iMID_VALUE;
            end
            if (issue && cnt == '0) scale <= mulR;
            for (int k = 0; k < N_MID; k++) if (addV && addIdx == IW'(k)) weight[k] <= addR;
        end
    end
    wu_tag_pipe #(.LAT(MUL_LAT), .IW(IW)) mulTags (
        .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(issue), .iIDX(IW'(cnt)), .oVALID(mulV), .oIDX(mulIdx)
    );
    wu_tag_pipe #(.LAT(ADD_LAT), .IW(IW)) addTags (
        .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(mulV), .iIDX(mulIdx), .oVALID(addV), .oIDX(addIdx)
    );
    fp_add_sub #(.LAT(ADD_LAT)) adder (.iCLK(iCLK), .iSUB(addSub), .iA(addA), .iB(addB), .oRESULT(addR));
    fp_mult #(.LAT(MUL_LAT)) mult (.iCLK(iCLK), .iA(mulA), .iB(mulB), .oRESULT(mulR));
    assign bus.oBUSY = state != IDLE && state != DONE;
    assign bus.oDONE = state == DONE;
    assign bus.oWEIGHT = weight;
endmodule
